// File: rtl/word_serializer.sv
// Parallel-to-serial word feeder: valid/ready word input, MSB-first bit stream with pause and sent-word counter.
// Optional macro SER_BACK_TO_BACK_EN lets the next word load on the last bit edge for gap-free streaming.
module word_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic lastBit;
    logic handshake;

    assign lastBit = (state_q == SHIFT) && (cnt_q == '0);

    // Reset gates in_ready so nothing is accepted while the block is being cleared.
`ifdef SER_BACK_TO_BACK_EN
    assign in_ready = !rst && ((state_q == IDLE) || (lastBit && !pause));
`else
    assign in_ready = !rst && (state_q == IDLE);
`endif

    assign handshake = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    shreg_d = in_data;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                    // handshake can only be true here in back-to-back builds
                    if (cnt_q == '0) begin
                        words_d = words_q + 1'b1;
                        if (handshake) begin
                            shreg_d = in_data;
                            cnt_d   = CNT_MAX;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    assign bit_out    = shreg_q[WIDTH-1];
    assign bit_valid  = (state_q == SHIFT) && !pause;
    assign bit_last   = lastBit && !pause;
    assign busy       = (state_q == SHIFT);
    assign words_sent = words_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: driver pushes each accepted word's bits into a queue,
// a monitor pops them as the DUT streams; small counter width exercises words_sent wrap.
module tb_word_serializer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             pause;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_last;
    logic             busy;
    logic [CNT_W-1:0] words_sent;

    word_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pause      (pause),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_last   (bit_last),
        .busy       (busy),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending serial bits, MSB first, of every accepted word.
    logic             expQ[$];
    int               pushedNow = 0;
    logic [CNT_W-1:0] expWords = '0;
    int               numChecks = 0;
    int               numFails = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // One clock cycle of stimulus; a word is accepted when valid meets ready before the edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic p, output logic accepted);
        in_valid = v;
        in_data  = d;
        pause    = p;
        #1;
        accepted = v && (in_ready === 1'b1) && !rst;
        if (accepted) begin
            for (int i = WIDTH - 1; i >= 0; i--) expQ.push_back(d[i]);
            pushedNow = WIDTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            applyStimulus(1'b1, d, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL handshake_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic idleCycles(input int n, input logic p);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, p, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 4 * WIDTH) begin
            idleCycles(1, 1'b0);
            n++;
        end
        if (expQ.size() != 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL drain_timeout: got %0d bits left expected 0", expQ.size());
        end
        idleCycles(1, 1'b0);
    endtask

    task automatic pulseReset(input int n);
        in_valid = 1'b0;
        pause    = 1'b0;
        rst      = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: the model is cleared on every reset edge and compared at each falling edge.
    initial begin : monitor
        logic rstEdge;
        int   live;
        logic expBusy;
        logic expReady;
        logic expBit;
        rstEdge = 1'b0;
        forever begin
            @(posedge clk);
            rstEdge = rst;
            if (rst) begin
                expQ.delete();
                expWords  = '0;
                pushedNow = 0;
            end
            @(negedge clk);
            if (rst) begin
                checkOutput("in_ready_in_reset", 32'(in_ready), 32'd0);
                if (rstEdge) begin
                    checkOutput("reset_bit_valid", 32'(bit_valid), 32'd0);
                    checkOutput("reset_bit_last", 32'(bit_last), 32'd0);
                    checkOutput("reset_bit_out", 32'(bit_out), 32'd0);
                    checkOutput("reset_busy", 32'(busy), 32'd0);
                    checkOutput("reset_words_sent", 32'(words_sent), 32'd0);
                end
            end else begin
                live     = expQ.size() - pushedNow;
                expBusy  = (live > 0);
`ifdef SER_BACK_TO_BACK_EN
                expReady = !expBusy || (live == 1 && !pause);
`else
                expReady = !expBusy;
`endif
                expBit   = expBusy ? expQ[0] : 1'b0;
                checkOutput("busy", 32'(busy), 32'(expBusy));
                checkOutput("in_ready", 32'(in_ready), 32'(expReady));
                checkOutput("words_sent", 32'(words_sent), 32'(expWords));
                checkOutput("bit_valid", 32'(bit_valid), 32'(expBusy && !pause));
                checkOutput("bit_out", 32'(bit_out), 32'(expBit));
                checkOutput("bit_last", 32'(bit_last), 32'(expBusy && !pause && live == 1));
                if (expBusy && !pause) begin
                    void'(expQ.pop_front());
                    if (live == 1) expWords = expWords + 1'b1;
                end
                pushedNow = 0;
            end
        end
    end

    initial begin : driver
        logic acc;
        in_valid = 1'b0;
        in_data  = '0;
        pause    = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        pulseReset(2);

        $display("[TB] single word D00B");
        sendWord(16'hD00B);
        drain();

        $display("[TB] single word with pause in cycles 3-5");
        sendWord(16'hD00B);
        idleCycles(2, 1'b0);
        idleCycles(3, 1'b1);
        drain();

        $display("[TB] two words with in_valid held");
        sendWord(16'hFFFF);
        sendWord(16'h0000);
        drain();

        $display("[TB] pause while idle still accepts");
        applyStimulus(1'b1, 16'hA5C3, 1'b1, acc);
        checkOutput("accept_with_pause_idle", 32'(acc), 32'd1);
        idleCycles(WIDTH - 1, 1'b0);
        idleCycles(2, 1'b1);
        drain();

        $display("[TB] reset mid-word");
        sendWord(16'h1234);
        idleCycles(7, 1'b0);
        pulseReset(1);
        sendWord(16'h8001);
        drain();

        $display("[TB] counter wrap over five words");
        for (int i = 0; i < 5; i++) begin
            sendWord(16'($urandom));
        end
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulseReset($urandom_range(1, 2));
            end else begin
                applyStimulus($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 4) == 0, acc);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
